quick_rs232: RTL and testbench



---
 rtl/quick_rs232_pkg.sv | 35 +++
 rtl/quick_rs232_fifo.sv | 54 +++++
 rtl/quick_rs232.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_quick_rs232.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/quick_rs232_pkg.sv
// quick_rs232 shared types: line-format encodings, FSM states and
// the bit-period helper used by the RX and TX paths.
package quick_rs232_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int STOP_ONE = 0;
  localparam int STOP_TWO = 1;

  localparam int FC_NONE    = 0;
  localparam int FC_RTS_CTS = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/quick_rs232_fifo.sv
// Receive FIFO: DEPTH x 8, head shown on rdata (0 when empty).
// Ports: push/wdata, pop, rdata, full, empty, free slot count.
module quick_rs232_fifo
  import quick_rs232_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign free    = (AW+1)'(DEPTH) - count;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/quick_rs232.sv
// RS-232 UART: synchronized RX into a FIFO, handshaked TX, RTS/CTS.
// Ports: clk, rst (async low), rx/tx, rts/cts, rx_* and tx_* buses.
module quick_rs232
  import quick_rs232_pkg::*;
#(
  parameter int CLK_FREQ                = 50000000,
  parameter int DEFAULT_BYTE_LEN        = 8,
  parameter int DEFAULT_PARITY          = 1,
  parameter int DEFAULT_STOP_BITS       = 0,
  parameter int DEFAULT_BAUD_RATE       = 115200,
  parameter int DEFAULT_RECV_BUFFER_LEN = 16,
  parameter int DEFAULT_FLOW_CONTROL    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       rts,
  output logic       cts,
  input  logic       rx_read,
  output logic       rx_err,
  output logic [7:0] rx_data,
  output logic       rx_byte_received,
  input  logic       tx_transaction,
  input  logic [7:0] tx_data,
  input  logic       tx_data_ready,
  output logic       tx_data_copied,
  output logic       tx_busy
);

  localparam int BT   = bit_ticks(CLK_FREQ, DEFAULT_BAUD_RATE);
  localparam int HALF = BT / 2;
  localparam int CW   = $clog2(BT + 1);
  localparam int FW   = $clog2(DEFAULT_RECV_BUFFER_LEN) + 1;

  localparam logic [CW-1:0] BT_END   = CW'(BT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [2:0]    LAST     = 3'(DEFAULT_BYTE_LEN - 1);
  localparam logic [2:0]    STOP_END = 3'(DEFAULT_STOP_BITS);
  localparam logic [7:0]    MASK     = 8'((1 << DEFAULT_BYTE_LEN) - 1);
  localparam logic          PAR_EN   = DEFAULT_PARITY != PAR_NONE;
  localparam logic          PAR_OD   = DEFAULT_PARITY == PAR_ODD;
  localparam logic          FC_ON    = DEFAULT_FLOW_CONTROL == FC_RTS_CTS;

  // RX synchronizer plus one extra stage for edge detection
  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_q;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_q    <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_q    <= rx_s;
    end
  end

  rx_state_t     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_buf, rx_buf_n;
  logic          rx_par, rx_par_n;
  logic          rx_rcv_n;
  logic          rx_err_n;
  logic          push;
  logic          par_bad;
  logic          ff_full;
  logic          ff_empty;
  logic [FW-1:0] ff_free;

  // rx_buf bits above the byte length stay 0, so the full XOR is safe
  assign par_bad = PAR_EN & (rx_par != (^rx_buf ^ PAR_OD));

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_idx_n = rx_idx;
    rx_buf_n = rx_buf;
    rx_par_n = rx_par;
    rx_rcv_n = 1'b0;
    rx_err_n = 1'b0;
    push     = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (rx_q && !rx_s) begin
          rx_st_n  = RX_START;
          rx_cnt_n = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_buf_n = '0;
          rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BT_END) begin
          rx_cnt_n         = '0;
          rx_buf_n[rx_idx] = rx_s;
          if (rx_idx == LAST)
            rx_st_n = PAR_EN ? RX_PARITY : RX_STOP;
          else
            rx_idx_n = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt == BT_END) begin
          rx_cnt_n = '0;
          rx_par_n = rx_s;
          rx_st_n  = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BT_END) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          if (!rx_s || par_bad || ff_full) begin
            rx_err_n = 1'b1;
          end else begin
            push     = 1'b1;
            rx_rcv_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st            <= RX_IDLE;
      rx_cnt           <= '0;
      rx_idx           <= '0;
      rx_buf           <= '0;
      rx_par           <= 1'b0;
      rx_byte_received <= 1'b0;
      rx_err           <= 1'b0;
    end else begin
      rx_st            <= rx_st_n;
      rx_cnt           <= rx_cnt_n;
      rx_idx           <= rx_idx_n;
      rx_buf           <= rx_buf_n;
      rx_par           <= rx_par_n;
      rx_byte_received <= rx_rcv_n;
      rx_err           <= rx_err_n;
    end
  end

  quick_rs232_fifo #(
    .DEPTH (DEFAULT_RECV_BUFFER_LEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rx_buf),
    .pop   (rx_read),
    .rdata (rx_data),
    .full  (ff_full),
    .empty (ff_empty),
    .free  (ff_free)
  );

  // keep one spare slot so a frame already in flight still fits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cts <= 1'b0;
    else
      cts <= FC_ON ? (ff_free >= FW'(2)) : 1'b1;
  end

  tx_state_t     tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_buf, tx_buf_n;
  logic          copied_n;
  logic          tx_bit;
  logic          latch;

  assign latch = tx_transaction & tx_data_ready & (rts | ~FC_ON);

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_idx_n = tx_idx;
    tx_buf_n = tx_buf;
    copied_n = 1'b0;
    tx_bit   = 1'b1;
    unique case (tx_st)
      TX_IDLE: begin
        if (latch) begin
          tx_buf_n = tx_data & MASK;
          copied_n = 1'b1;
          tx_cnt_n = '0;
          tx_st_n  = TX_START;
        end
      end
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_cnt == BT_END) begin
          tx_cnt_n = '0;
          tx_idx_n = '0;
          tx_st_n  = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        tx_bit = tx_buf[tx_idx];
        if (tx_cnt == BT_END) begin
          tx_cnt_n = '0;
          if (tx_idx == LAST) begin
            tx_idx_n = '0;
            tx_st_n  = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_PARITY: begin
        tx_bit = ^tx_buf ^ PAR_OD;
        if (tx_cnt == BT_END) begin
          tx_cnt_n = '0;
          tx_idx_n = '0;
          tx_st_n  = TX_STOP;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == BT_END) begin
          tx_cnt_n = '0;
          if (tx_idx == STOP_END)
            tx_st_n = TX_IDLE;
          else
            tx_idx_n = tx_idx + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line trails the
  // state by one cycle and starts just after the copied pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st          <= TX_IDLE;
      tx_cnt         <= '0;
      tx_idx         <= '0;
      tx_buf         <= '0;
      tx             <= 1'b1;
      tx_busy        <= 1'b0;
      tx_data_copied <= 1'b0;
    end else begin
      tx_st          <= tx_st_n;
      tx_cnt         <= tx_cnt_n;
      tx_idx         <= tx_idx_n;
      tx_buf         <= tx_buf_n;
      tx             <= tx_bit;
      tx_busy        <= tx_st_n != TX_IDLE;
      tx_data_copied <= copied_n;
    end
  end

endmodule

// File: tb/tb_quick_rs232.sv
// Randomized bench for quick_rs232 against a queue-based line model.
// Even parity, one stop bit, RTS/CTS on, 16-cycle bit period.
module tb_quick_rs232;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BT       = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic       rts;
  logic       cts;
  logic       rx_read;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       rx_byte_received;
  logic       tx_transaction;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;
  int n_rcv = 0;
  int n_err = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  quick_rs232 #(
    .CLK_FREQ                (CLK_FREQ),
    .DEFAULT_BYTE_LEN        (8),
    .DEFAULT_PARITY          (1),
    .DEFAULT_STOP_BITS       (0),
    .DEFAULT_BAUD_RATE       (BAUD),
    .DEFAULT_RECV_BUFFER_LEN (DEPTH),
    .DEFAULT_FLOW_CONTROL    (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .tx               (tx),
    .rts              (rts),
    .cts              (cts),
    .rx_read          (rx_read),
    .rx_err           (rx_err),
    .rx_data          (rx_data),
    .rx_byte_received (rx_byte_received),
    .tx_transaction   (tx_transaction),
    .tx_data          (tx_data),
    .tx_data_ready    (tx_data_ready),
    .tx_data_copied   (tx_data_copied),
    .tx_busy          (tx_busy)
  );

  always @(negedge clk) begin
    if (rx_byte_received) n_rcv++;
    if (rx_err) n_err++;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop,
                            int nbits);
    logic [10:0] f;
    f = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (BT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_expect(logic [7:0] b, bit bad_par, bit bad_stop);
    int r0;
    int e0;
    bit ok;
    r0 = n_rcv;
    e0 = n_err;
    ok = !bad_par && !bad_stop && (q.size() < DEPTH);
    send_frame(b, bad_par, bad_stop, 11);
    if (ok) q.push_back(b);
    check("rx_rcv", n_rcv - r0, ok);
    check("rx_err", n_err - e0, !ok);
    check("rx_head", rx_data, q.size() ? q[0] : 8'h00);
    check("cts", cts, (DEPTH - q.size()) >= 2);
  endtask

  task automatic pop_expect();
    check("pop_head", rx_data, q.size() ? q[0] : 8'h00);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    if (q.size()) void'(q.pop_front());
  endtask

  task automatic tx_frame(logic [7:0] b);
    logic [10:0] f;
    int w;
    int ncop;
    f = {1'b1, ^b, b, 1'b0};
    w = 0;
    ncop = 1;
    tx_data = b;
    tx_data_ready = 1'b1;
    tx_transaction = 1'b1;
    while (!tx_data_copied && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("tx_latch", w < 100, 1);
    tx_transaction = 1'b0;
    tx_data_ready = 1'b0;
    check("tx_busy_rise", tx_busy, 1);
    for (int k = 1; k <= 11 * BT; k++) begin
      @(negedge clk);
      if (tx_data_copied) ncop++;
      if ((k - 1) % BT == BT / 2)
        check($sformatf("tx_bit%0d", (k - 1) / BT), tx, f[(k - 1) / BT]);
      if (k == 11 * BT - 1) check("tx_busy_end", tx_busy, 1);
      if (k == 11 * BT) check("tx_busy_fall", tx_busy, 0);
    end
    check("tx_copied_cnt", ncop, 1);
  endtask

  initial begin
    int r0;
    int e0;
    int cp;
    rst = 1'b0;
    rx = 1'b1;
    rts = 1'b1;
    rx_read = 1'b0;
    tx_transaction = 1'b0;
    tx_data_ready = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_cts", cts, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rcv", rx_byte_received, 0);
    check("rst_copied", tx_data_copied, 0);
    check("rst_busy", tx_busy, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("cts_up", cts, 1);

    rx_expect(8'h53, 0, 0);
    pop_expect();
    rx_expect(8'h53, 1, 0);
    rx_expect(8'h53, 0, 1);
    for (int i = 0; i < 4; i++) rx_expect(8'($urandom), 0, 0);
    while (q.size()) pop_expect();
    check("empty_after_pops", rx_data, 0);

    for (int i = 1; i <= DEPTH + 1; i++) rx_expect(8'($urandom), 0, 0);
    for (int i = 0; i < DEPTH; i++) pop_expect();
    @(negedge clk);
    check("drained", rx_data, 0);
    check("cts_back", cts, 1);

    tx_frame(8'hA5);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom));

    rts = 1'b0;
    tx_transaction = 1'b1;
    tx_data_ready = 1'b1;
    cp = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_data_copied) cp++;
    end
    check("rts_block_copied", cp, 0);
    check("rts_block_busy", tx_busy, 0);
    tx_transaction = 1'b0;
    tx_data_ready = 1'b0;
    rts = 1'b1;
    @(negedge clk);

    tx_data = 8'h3C;
    tx_data_ready = 1'b1;
    tx_transaction = 1'b1;
    repeat (5 * BT) @(negedge clk);
    tx_transaction = 1'b0;
    tx_data_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("midtx_tx", tx, 1);
    check("midtx_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    r0 = n_rcv;
    e0 = n_err;
    send_frame(8'h53, 0, 0, 5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * BT) @(negedge clk);
    check("midrx_rcv", n_rcv - r0, 0);
    check("midrx_err", n_err - e0, 0);
    check("midrx_empty", rx_data, 0);
    q.delete();

    rx_expect(8'h53, 0, 0);
    pop_expect();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
